// File: rtl/fifo_axi_pkg.sv
// Shared types and constants for the FIFO-to-AXI burst writer.
package fifo_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Burst start address register walking linearly through a circular region,
// stepping one burst per advance strobe and wrapping at the region end.
module burst_addr_gen #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN   = ADDR_WIDTH'('h10000),
    parameter logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(64)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  advance_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    localparam logic [ADDR_WIDTH-1:0] END_ADDR = BASE_ADDR + ADDR_SPAN;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH-1:0] addr_inc;

    always_comb begin
        addr_inc = addr_q + BURST_BYTES;
        addr_d   = addr_q;
        if (advance_i) begin
            addr_d = (addr_inc == END_ADDR) ? BASE_ADDR : addr_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            addr_q <= BASE_ADDR;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/fifo_axi_burst_writer.sv
// Drains a show-ahead FIFO into DDR as AXI4 INCR write bursts, one outstanding.
// Optional BRESP error counter enabled by defining FIFO_AXI_WR_ERR_CNT_EN.
//
// state   | meaning
// IDLE    | waiting for enable and a non-empty FIFO
// ADDR    | AW presented, held until awready
// DATA    | streaming BURST_LEN beats straight from the FIFO head
// RESP    | waiting for the write response
module fifo_axi_burst_writer
    import fifo_axi_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    BURST_LEN  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN  = ADDR_WIDTH'('h10000)
) (
    input  logic                    rd_clk,
    input  logic                    rd_rstn,
    input  logic                    enable,
    input  logic                    fifo_empty,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    output logic                    fifo_rd_en,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic                    busy,
    output logic [31:0]             burst_cnt,
    output logic [15:0]             err_cnt
);

    localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);

    wr_state_e   state_q, state_d;
    logic [7:0]  beat_q, beat_d;
    logic [31:0] burst_cnt_q, burst_cnt_d;
    logic        aw_valid, w_valid, w_fire, b_ready, b_fire;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        w_fire   = 1'b0;
        b_ready  = 1'b0;
        b_fire   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                aw_valid = 1'b1;
                if (m_axi_awready) begin
                    state_d = ST_DATA;
                    beat_d  = '0;
                end
            end
            ST_DATA: begin
                // An empty FIFO simply stalls the burst; no filler beats are sent.
                w_valid = !fifo_empty;
                w_fire  = w_valid && m_axi_wready;
                if (w_fire) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            ST_RESP: begin
                b_ready = 1'b1;
                b_fire  = m_axi_bvalid;
                if (m_axi_bvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign burst_cnt_d = burst_cnt_q + (b_fire ? 32'd1 : 32'd0);

    always_ff @(posedge rd_clk) begin
        if (!rd_rstn) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    burst_addr_gen #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BASE_ADDR   (BASE_ADDR),
        .ADDR_SPAN   (ADDR_SPAN),
        .BURST_BYTES (BURST_BYTES)
    ) u_addr_gen (
        .clk_i     (rd_clk),
        .rstn_i    (rd_rstn),
        .advance_i (b_fire),
        .addr_o    (m_axi_awaddr)
    );

`ifdef FIFO_AXI_WR_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (b_fire && (m_axi_bresp != AXI_RESP_OKAY) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rstn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^m_axi_bresp;
    assign err_cnt      = '0;
`endif

    assign fifo_rd_en    = w_fire;
    assign m_axi_awlen   = LAST_BEAT;
    assign m_axi_awsize  = 3'(clog2(DATA_WIDTH / 8));
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awvalid = aw_valid;
    assign m_axi_wdata   = fifo_rd_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state_q == ST_DATA) && (beat_q == LAST_BEAT);
    assign m_axi_wvalid  = w_valid;
    assign m_axi_bready  = b_ready;
    assign busy          = (state_q != ST_IDLE);
    assign burst_cnt     = burst_cnt_q;

endmodule

// File: tb/tb_fifo_axi_burst_writer.sv
// Bench for fifo_axi_burst_writer: FIFO, AXI slave and B responder models,
// compared against a queue-based model of the expected write stream.
module tb_fifo_axi_burst_writer;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          BL    = 16;
    localparam logic [31:0] BASE  = 32'h0;
    localparam logic [31:0] SPAN  = 32'h80;
    localparam int          BYTES = BL * DW / 8;
`ifdef FIFO_AXI_WR_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          rd_clk = 1'b0;
    logic          rd_rstn;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic          busy;
    logic [31:0]   burst_cnt;
    logic [15:0]   err_cnt;

    fifo_axi_burst_writer #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .BURST_LEN (BL),
        .BASE_ADDR (BASE), .ADDR_SPAN (SPAN)
    ) dut (
        .rd_clk (rd_clk), .rd_rstn (rd_rstn), .enable (enable),
        .fifo_empty (fifo_empty), .fifo_rd_data (fifo_rd_data), .fifo_rd_en (fifo_rd_en),
        .m_axi_awaddr (m_axi_awaddr), .m_axi_awlen (m_axi_awlen), .m_axi_awsize (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst), .m_axi_awvalid (m_axi_awvalid), .m_axi_awready (m_axi_awready),
        .m_axi_wdata (m_axi_wdata), .m_axi_wstrb (m_axi_wstrb), .m_axi_wlast (m_axi_wlast),
        .m_axi_wvalid (m_axi_wvalid), .m_axi_wready (m_axi_wready),
        .m_axi_bresp (m_axi_bresp), .m_axi_bvalid (m_axi_bvalid), .m_axi_bready (m_axi_bready),
        .busy (busy), .burst_cnt (burst_cnt), .err_cnt (err_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: the bench writes wr_ptr, the pop monitor writes rd_ptr.
    logic [DW-1:0] fifo_mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign fifo_rd_data = fifo_mem[rd_ptr % 4096];

    // Ready generation controlled by the tests.
    bit rand_ready = 1'b0;
    bit aw_block   = 1'b0;
    always @(negedge rd_clk) begin
        m_axi_awready = aw_block ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        m_axi_wready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // B responder: one response per wlast beat; burst number err_burst_idx gets SLVERR.
    int resp_idx      = 0;
    int err_burst_idx = -1;
    always @(posedge rd_clk) begin
        if (!rd_rstn) begin
            m_axi_bvalid <= 1'b0;
            m_axi_bresp  <= 2'b00;
        end else begin
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if (m_axi_wvalid && m_axi_wready && m_axi_wlast) begin
                m_axi_bvalid <= 1'b1;
                m_axi_bresp  <= (resp_idx == err_burst_idx) ? 2'b10 : 2'b00;
                resp_idx     <= resp_idx + 1;
            end
        end
    end

    // Bus monitor: logs handshakes and counts protocol violations.
    logic [DW-1:0] w_data [0:4095];
    logic          w_last [0:4095];
    logic [AW-1:0] aw_log [0:255];
    int w_n = 0, aw_n = 0, b_n = 0;
    int viol_pop_empty = 0, viol_rd_en = 0, viol_w_noaw = 0, viol_aw_drop = 0, viol_fields = 0;
    logic          mon_open = 1'b0;
    logic          prev_aw_pend = 1'b0;
    logic [AW-1:0] prev_awaddr = '0;
    always @(posedge rd_clk) begin
        if (!rd_rstn) begin
            mon_open     <= 1'b0;
            prev_aw_pend <= 1'b0;
        end else begin
            if (fifo_rd_en) begin
                if (fifo_empty) viol_pop_empty <= viol_pop_empty + 1;
                rd_ptr <= rd_ptr + 1;
            end
            if (fifo_rd_en !== (m_axi_wvalid && m_axi_wready)) viol_rd_en <= viol_rd_en + 1;
            if (prev_aw_pend && (!m_axi_awvalid || m_axi_awaddr !== prev_awaddr))
                viol_aw_drop <= viol_aw_drop + 1;
            prev_aw_pend <= m_axi_awvalid && !m_axi_awready;
            prev_awaddr  <= m_axi_awaddr;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_log[aw_n % 256] <= m_axi_awaddr;
                aw_n     <= aw_n + 1;
                mon_open <= 1'b1;
                if (m_axi_awlen !== 8'(BL - 1) || m_axi_awsize !== 3'd2 || m_axi_awburst !== 2'b01)
                    viol_fields <= viol_fields + 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (!mon_open) viol_w_noaw <= viol_w_noaw + 1;
                if (m_axi_wstrb !== '1) viol_fields <= viol_fields + 1;
                w_data[w_n % 4096] <= m_axi_wdata;
                w_last[w_n % 4096] <= m_axi_wlast;
                w_n <= w_n + 1;
                if (m_axi_wlast) mon_open <= 1'b0;
            end
            if (m_axi_bvalid && m_axi_bready) b_n <= b_n + 1;
        end
    end

    // Reference model: pushed words in order, bursts and errors since reset.
    logic [DW-1:0] model_q [$];
    int model_bursts = 0;
    int model_err    = 0;
    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] exp_addr(input int k);
        return BASE + 32'((k * BYTES) % int'(SPAN));
    endfunction

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] word);
        fifo_mem[wr_ptr % 4096] = word;
        wr_ptr = wr_ptr + 1;
        model_q.push_back(word);
    endtask

    task automatic wait_bursts(input int target, output bit ok);
        int n;
        n = 0;
        while (b_n < target && n < 3000) begin
            tick();
            n++;
        end
        ok = (b_n >= target);
    endtask

    task automatic wait_beats(input int target, output bit ok);
        int n;
        n = 0;
        while (w_n < target && n < 1000) begin
            tick();
            n++;
        end
        ok = (w_n >= target);
    endtask

    task automatic test_reset();
        rd_rstn = 1'b0;
        enable  = 1'b0;
        repeat (3) tick();
        checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, fifo_rd_en, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_valids: got %b want 00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, fifo_rd_en, busy}); end
        checks++; if (m_axi_awaddr !== BASE) begin
            errors++; $display("FAIL reset_awaddr: got %h want %h", m_axi_awaddr, BASE); end
        checks++; if (burst_cnt !== 32'd0 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", burst_cnt, err_cnt); end
        checks++; if (m_axi_awlen !== 8'd15 || m_axi_awsize !== 3'd2 || m_axi_awburst !== 2'b01) begin
            errors++; $display("FAIL reset_awfields: got %0d/%0d/%0d want 15/2/1",
                m_axi_awlen, m_axi_awsize, m_axi_awburst); end
        rd_rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_burst();
        int b0, w0, a0, r0;
        bit ok;
        logic [DW-1:0] exp;
        b0 = b_n; w0 = w_n; a0 = aw_n; r0 = rd_ptr;
        for (int i = 0; i < BL; i++) push(DW'(i));
        enable = 1'b1;
        wait_bursts(b0 + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d bursts want %0d", b_n - b0, 1); end
        checks++; if (aw_n - a0 != 1 || aw_log[a0 % 256] !== exp_addr(model_bursts)) begin
            errors++; $display("FAIL single_aw: got %0d AWs addr %h want 1 addr %h",
                aw_n - a0, aw_log[a0 % 256], exp_addr(model_bursts)); end
        checks++; if (w_n - w0 != BL || rd_ptr - r0 != BL) begin
            errors++; $display("FAIL single_beats: got %0d beats %0d pops want %0d", w_n - w0, rd_ptr - r0, BL); end
        for (int i = 0; i < BL; i++) begin
            exp = model_q.pop_front();
            checks++; if (w_data[(w0 + i) % 4096] !== exp || w_last[(w0 + i) % 4096] !== (i == BL - 1)) begin
                errors++; $display("FAIL single_beat[%0d]: got %h last %b want %h last %b",
                    i, w_data[(w0 + i) % 4096], w_last[(w0 + i) % 4096], exp, (i == BL - 1)); end
        end
        model_bursts++;
        tick();
        checks++; if (burst_cnt !== 32'(model_bursts) || busy !== 1'b0) begin
            errors++; $display("FAIL single_cnt: got cnt %0d busy %b want %0d busy 0", burst_cnt, busy, model_bursts); end
        checks++; if (m_axi_awaddr !== exp_addr(model_bursts)) begin
            errors++; $display("FAIL single_next_addr: got %h want %h", m_axi_awaddr, exp_addr(model_bursts)); end
    endtask

    task automatic test_gap();
        int b0, w0, a0, r_gap;
        bit ok;
        logic [DW-1:0] exp;
        b0 = b_n; w0 = w_n; a0 = aw_n;
        for (int i = 0; i < 6; i++) push($urandom);
        wait_beats(w0 + 6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL gap_start_timeout: got %0d beats want 6", w_n - w0); end
        r_gap = rd_ptr;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (m_axi_wvalid !== 1'b0 || fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL gap_cycle[%0d]: got wvalid %b rd_en %b busy %b want 0 0 1",
                    c, m_axi_wvalid, fifo_rd_en, busy); end
        end
        checks++; if (rd_ptr != r_gap) begin errors++; $display("FAIL gap_pops: got %0d want 0", rd_ptr - r_gap); end
        for (int i = 0; i < 10; i++) push($urandom);
        wait_bursts(b0 + 1, ok);
        checks++; if (!ok || aw_n - a0 != 1 || w_n - w0 != BL) begin
            errors++; $display("FAIL gap_burst: got ok %b %0d AWs %0d beats want 1 1 %0d", ok, aw_n - a0, w_n - w0, BL); end
        for (int i = 0; i < BL; i++) begin
            exp = model_q.pop_front();
            checks++; if (w_data[(w0 + i) % 4096] !== exp || w_last[(w0 + i) % 4096] !== (i == BL - 1)) begin
                errors++; $display("FAIL gap_beat[%0d]: got %h last %b want %h last %b",
                    i, w_data[(w0 + i) % 4096], w_last[(w0 + i) % 4096], exp, (i == BL - 1)); end
        end
        model_bursts++;
    endtask

    task automatic test_addr_wrap();
        int b0, w0, a0;
        bit ok;
        logic [DW-1:0] exp;
        b0 = b_n; w0 = w_n; a0 = aw_n;
        rand_ready = 1'b1;
        for (int i = 0; i < 4 * BL; i++) push($urandom);
        wait_bursts(b0 + 4, ok);
        rand_ready = 1'b0;
        checks++; if (!ok || aw_n - a0 != 4) begin
            errors++; $display("FAIL wrap_bursts: got ok %b %0d AWs want 1 4", ok, aw_n - a0); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (aw_log[(a0 + k) % 256] !== exp_addr(model_bursts + k)) begin
                errors++; $display("FAIL wrap_addr[%0d]: got %h want %h",
                    k, aw_log[(a0 + k) % 256], exp_addr(model_bursts + k)); end
        end
        for (int i = 0; i < 4 * BL; i++) begin
            exp = model_q.pop_front();
            checks++; if (w_data[(w0 + i) % 4096] !== exp || w_last[(w0 + i) % 4096] !== ((i % BL) == BL - 1)) begin
                errors++; $display("FAIL wrap_beat[%0d]: got %h last %b want %h last %b",
                    i, w_data[(w0 + i) % 4096], w_last[(w0 + i) % 4096], exp, ((i % BL) == BL - 1)); end
        end
        model_bursts += 4;
        tick();
        checks++; if (burst_cnt !== 32'(model_bursts)) begin
            errors++; $display("FAIL wrap_cnt: got %0d want %0d", burst_cnt, model_bursts); end
    endtask

    task automatic test_aw_stall();
        int b0, w0;
        bit ok;
        logic [DW-1:0] exp;
        b0 = b_n; w0 = w_n;
        aw_block = 1'b1;
        tick();
        for (int i = 0; i < BL; i++) push($urandom);
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++; if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== exp_addr(model_bursts) || w_n != w0) begin
                errors++; $display("FAIL stall_cycle[%0d]: got awvalid %b addr %h beats %0d want 1 %h 0",
                    c, m_axi_awvalid, m_axi_awaddr, w_n - w0, exp_addr(model_bursts)); end
        end
        aw_block = 1'b0;
        wait_bursts(b0 + 1, ok);
        checks++; if (!ok || w_n - w0 != BL) begin
            errors++; $display("FAIL stall_burst: got ok %b beats %0d want 1 %0d", ok, w_n - w0, BL); end
        for (int i = 0; i < BL; i++) begin
            exp = model_q.pop_front();
            checks++; if (w_data[(w0 + i) % 4096] !== exp) begin
                errors++; $display("FAIL stall_beat[%0d]: got %h want %h", i, w_data[(w0 + i) % 4096], exp); end
        end
        model_bursts++;
    endtask

    task automatic test_bresp_err();
        int b0, a0;
        bit ok;
        b0 = b_n; a0 = aw_n;
        err_burst_idx = resp_idx + 1;
        for (int i = 0; i < 2 * BL; i++) push($urandom);
        wait_bursts(b0 + 2, ok);
        model_q.delete();
        model_err++;
        tick();
        checks++; if (!ok) begin errors++; $display("FAIL err_timeout: got %0d bursts want 2", b_n - b0); end
        checks++; if (aw_log[(a0 + 1) % 256] !== exp_addr(model_bursts + 1)) begin
            errors++; $display("FAIL err_addr: got %h want %h", aw_log[(a0 + 1) % 256], exp_addr(model_bursts + 1)); end
        model_bursts += 2;
        checks++; if (err_cnt !== (ERR_EN ? 16'(model_err) : 16'd0)) begin
            errors++; $display("FAIL err_cnt: got %0d want %0d", err_cnt, ERR_EN ? model_err : 0); end
        checks++; if (burst_cnt !== 32'(model_bursts) || m_axi_awaddr !== exp_addr(model_bursts)) begin
            errors++; $display("FAIL err_advance: got cnt %0d addr %h want %0d %h",
                burst_cnt, m_axi_awaddr, model_bursts, exp_addr(model_bursts)); end
    endtask

    task automatic test_enable_drop();
        int b0, a0, w0;
        bit ok;
        logic [DW-1:0] exp;
        b0 = b_n; a0 = aw_n; w0 = w_n;
        for (int i = 0; i < 2 * BL; i++) push($urandom);
        wait_beats(w0 + 3, ok);
        enable = 1'b0;
        wait_bursts(b0 + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_timeout: got %0d bursts want 1", b_n - b0); end
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++; if (busy !== 1'b0 || aw_n - a0 != 1) begin
                errors++; $display("FAIL endrop_hold[%0d]: got busy %b AWs %0d want 0 1", c, busy, aw_n - a0); end
        end
        checks++; if (wr_ptr - rd_ptr != BL) begin
            errors++; $display("FAIL endrop_level: got %0d words want %0d", wr_ptr - rd_ptr, BL); end
        enable = 1'b1;
        wait_bursts(b0 + 2, ok);
        checks++; if (!ok || w_n - w0 != 2 * BL) begin
            errors++; $display("FAIL endrop_resume: got ok %b beats %0d want 1 %0d", ok, w_n - w0, 2 * BL); end
        for (int i = 0; i < 2 * BL; i++) begin
            exp = model_q.pop_front();
            checks++; if (w_data[(w0 + i) % 4096] !== exp) begin
                errors++; $display("FAIL endrop_beat[%0d]: got %h want %h", i, w_data[(w0 + i) % 4096], exp); end
        end
        model_bursts += 2;
    endtask

    task automatic test_reset_mid_burst();
        int b0, a0, w0;
        bit ok;
        w0 = w_n;
        for (int i = 0; i < BL; i++) push($urandom);
        wait_beats(w0 + 7, ok);
        checks++; if (!ok || busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_start: got ok %b busy %b want 1 1", ok, busy); end
        enable  = 1'b0;
        rd_rstn = 1'b0;
        tick();
        checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, fifo_rd_en, busy} !== 5'b0) begin
            errors++; $display("FAIL rstmid_valids: got %b want 00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, fifo_rd_en, busy}); end
        checks++; if (m_axi_awaddr !== BASE || burst_cnt !== 32'd0 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL rstmid_state: got addr %h cnt %0d err %0d want %h 0 0",
                m_axi_awaddr, burst_cnt, err_cnt, BASE); end
        wr_ptr = rd_ptr;
        model_q.delete();
        model_bursts = 0;
        model_err    = 0;
        tick();
        rd_rstn = 1'b1;
        tick();
        b0 = b_n; a0 = aw_n;
        for (int i = 0; i < BL; i++) push($urandom);
        enable = 1'b1;
        wait_bursts(b0 + 1, ok);
        model_q.delete();
        tick();
        checks++; if (!ok || aw_log[a0 % 256] !== BASE || burst_cnt !== 32'd1) begin
            errors++; $display("FAIL rstmid_restart: got ok %b addr %h cnt %0d want 1 %h 1",
                ok, aw_log[a0 % 256], burst_cnt, BASE); end
    endtask

    task automatic test_protocol();
        checks++; if (viol_pop_empty != 0 || viol_rd_en != 0) begin
            errors++; $display("FAIL proto_pop: got %0d empty pops %0d rd_en mismatches want 0 0",
                viol_pop_empty, viol_rd_en); end
        checks++; if (viol_w_noaw != 0 || viol_aw_drop != 0 || viol_fields != 0) begin
            errors++; $display("FAIL proto_axi: got %0d W-before-AW %0d AW drops %0d field errors want 0 0 0",
                viol_w_noaw, viol_aw_drop, viol_fields); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_gap();
        test_addr_wrap();
        test_aw_stall();
        test_bresp_err();
        test_enable_drop();
        test_reset_mid_burst();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
